ps2_frame_reader: RTL and testbench
===================================

Name: ps2_frame_reader

Overview:
- PS/2 device-to-host receiver. Passively samples the PS/2 clock and data lines at a slow sampling rate and assembles one 11-bit frame: start, 8 data, parity, stop.
- Reports frame progress, completion and error to the PS/2 command/listen controller.
- Never drives the bus; a separate transmitter shares PS2C/PS2D.

Parameters:
- TIMEOUT_TICKS, 100, sampling ticks without a PS2C falling edge mid-frame before the frame is aborted (2 ms at 50 kHz).

Ports:
- qzt_clk  in  1  system clock; all logic is synchronous to its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clk_main_loop  in  1  slow sampling clock (nominal 50 kHz, derived from qzt_clk); its rising edges are sample points.
- enable  in  1  receiver enabled while high.
- PS2C  inout  1  PS/2 clock; always high-Z from this block.
- PS2D  inout  1  PS/2 data; always high-Z from this block.
- reading  out  1  high while a frame is in progress.
- data  out  11  last completed frame, in arrival order.
- done  out  1  one-qzt_clk pulse on frame completion.
- err  out  1  frame error flag.

Behaviour:
- Reset (async, rst_n=0): data=0, reading=0, done=0, err=0, bit counter=0, state IDLE.
- Synchronisation and sampling:
  - clk_main_loop, PS2C and PS2D each pass through a 2-flop synchroniser on qzt_clk.
  - A sample tick is a one-cycle strobe on a synchronised 0->1 transition of clk_main_loop.
  - On each tick, register PS2C and PS2D. A PS2C falling edge = previous tick sample 1, current tick sample 0.
  - PS2D is taken from the same tick that detects the falling edge.
- States: IDLE, RECEIVE, FINISH.
- IDLE:
  - reading=0.
  - On a falling edge with enable=1 and PS2D=0 (start bit): shift in the 0, set bit count=1, clear err, set reading=1, go to RECEIVE.
  - A falling edge with PS2D=1 is ignored.
- RECEIVE:
  - On each falling edge, shift left: shreg <= {shreg[9:0], PS2D} and increment the count.
  - When the count reaches 11, go to FINISH.
  - The timeout counter is cleared on every falling edge and incremented on every other tick.
  - Reaching TIMEOUT_TICKS aborts the frame: reading=0, err=1, no done pulse, data unchanged, go to IDLE.
- FINISH (one qzt_clk cycle):
  - data <= shreg. Frame layout: data[10] = start, data[9] = d0 ... data[2] = d7, data[1] = parity, data[0] = stop.
  - done=1 for exactly this cycle; reading=0 in the same cycle.
  - err <= (data[10]==1) | (data[0]==0) | (XOR of data[9:1] == 0), i.e. odd parity is required.
  - The frame is still reported (done pulses and data updates) when err=1.
  - Go to IDLE.
- err holds its value until the next start bit or reset.
- enable=0 at any time: immediately return to IDLE, reading=0, no done, data and err unchanged; the bus is ignored.
- enable rising mid-transmission: the first falling edge with PS2D=0 is treated as a start bit; no frame alignment recovery beyond the timeout.
- done and a new start bit cannot coincide: FINISH lasts one cycle and ticks are far slower than qzt_clk.
- Bus requirement: at the 50 kHz tick, PS/2 clock half-periods of 30-50 us give 1-3 samples per level; half-periods shorter than one tick period are unsupported.

Test Plan:
- Valid ACK byte 0xFA (line order 0,0,1,0,1,1,1,1,1,1,1) at 12.5 kHz PS2C -> reading high from the first falling edge to completion; a single done pulse; data=11'h17F, data[9:2]=8'h5F, err=0.
- Same byte with parity bit 0 -> done pulses, data=11'h17D, err=1.
- Stop bit 0 (last line bit 0) -> data=11'h17E, err=1; the next good frame clears err to 0 and gives data=11'h17F.
- PS2C stops after 5 bits -> after TIMEOUT_TICKS ticks, reading=0, err=1, no done, data keeps its previous value.
- enable=0 before and during a frame -> no reading, no done. Deassert enable after 4 bits -> reading drops within 3 qzt_clk cycles and no done follows.
- Falling edge with PS2D=1 while idle, then a valid frame -> the first edge is ignored, the frame is received correctly. Assert rst_n=0 mid-frame -> all outputs 0 immediately, even with qzt_clk stopped.

Source files
------------

// File: rtl/ps2_frame_reader.sv
// ps2_frame_reader: passive PS/2 device-to-host frame receiver (start, 8 data, parity, stop)
//   qzt_clk, rst_n   system clock, async active-low reset
//   clk_main_loop    slow sampling clock; each synchronised rising edge is a sample tick
//   enable           receiver enabled while high
//   PS2C, PS2D       PS/2 bus lines, only ever observed (left high-Z)
//   reading          frame in progress
//   data             last completed frame, data[10] = first bit on the line
//   done             one-cycle pulse on frame completion
//   err              framing/parity error or timeout, held until the next start bit
module ps2_frame_reader #(
   parameter int TIMEOUT_TICKS = 100
) (
   input  logic        qzt_clk,
   input  logic        rst_n,
   input  logic        clk_main_loop,
   input  logic        enable,
   inout  wire         PS2C,
   inout  wire         PS2D,
   output logic        reading,
   output logic [10:0] data,
   output logic        done,
   output logic        err
);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   typedef enum logic [1:0] {IDLE, RECEIVE, FINISH} state_t;
   state_t         state_q, state_d;
   logic [2:0]     cml_q;
   logic [1:0]     c_sync_q, d_sync_q;
   logic           c_smp_q;
   logic [3:0]     cnt_q, cnt_d;
   logic [10:0]    shreg_q, shreg_d, data_q, data_d;
   logic           err_q, err_d;
   logic [TW-1:0]  to_q, to_d;
   logic           tick, fall, bit_in;
   assign tick   = cml_q[1] & ~cml_q[2];
   // the sample taken on this tick is compared with the previous tick's sample
   assign fall   = tick & c_smp_q & ~c_sync_q[1];
   assign bit_in = d_sync_q[1];
   always_ff @(posedge qzt_clk or negedge rst_n) begin
      if (!rst_n) begin
         cml_q    <= '0;
         c_sync_q <= 2'b11;
         d_sync_q <= 2'b11;
         c_smp_q  <= 1'b1;
         state_q  <= IDLE;
         cnt_q    <= '0;
         shreg_q  <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         to_q     <= '0;
      end else begin
         cml_q    <= {cml_q[1:0], clk_main_loop};
         c_sync_q <= {c_sync_q[0], PS2C};
         d_sync_q <= {d_sync_q[0], PS2D};
         c_smp_q  <= tick ? c_sync_q[1] : c_smp_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shreg_q  <= shreg_d;
         data_q   <= data_d;
         err_q    <= err_d;
         to_q     <= to_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      err_d   = err_q;
      to_d    = to_q;
      if (!enable) state_d = IDLE;
      else case (state_q)
         IDLE: if (fall && !bit_in) begin
            shreg_d = {shreg_q[9:0], 1'b0};
            cnt_d   = 4'd1;
            err_d   = 1'b0;
            to_d    = '0;
            state_d = RECEIVE;
         end
         RECEIVE: if (fall) begin
            shreg_d = {shreg_q[9:0], bit_in};
            cnt_d   = cnt_q + 4'd1;
            to_d    = '0;
            state_d = (cnt_q == 4'd10) ? FINISH : RECEIVE;
         end else if (tick) begin
            to_d = to_q + 1'b1;
            if (to_q == TW'(TIMEOUT_TICKS - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         FINISH: begin
            data_d  = shreg_q;
            // start must be 0, stop must be 1, data+parity must have odd weight
            err_d   = shreg_q[10] | ~shreg_q[0] | ~(^shreg_q[9:1]);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign reading = (state_q == RECEIVE);
   assign done    = (state_q == FINISH) & enable;
   assign data    = data_q;
   assign err     = err_q;
endmodule

// File: tb/tb_ps2_frame_reader.sv
// tb_ps2_frame_reader: scoreboard bench for ps2_frame_reader
module tb_ps2_frame_reader;
   localparam int HALF = 400;
   logic        qzt_clk = 1'b0;
   logic        clk_en = 1'b1;
   logic        cml = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        c_drv = 1'b1;
   logic        d_drv = 1'b1;
   wire         ps2c, ps2d;
   logic        reading, done, err;
   logic [10:0] data;
   int          n_checks = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   int          rd_hi;
   int          d0;
   logic        saw_reading = 1'b0;
   logic        chk_pend = 1'b0;
   logic [11:0] exp_v;
   logic [11:0] sb_q[$];
   assign ps2c = c_drv;
   assign ps2d = d_drv;
   ps2_frame_reader #(.TIMEOUT_TICKS(100)) dut (
      .qzt_clk(qzt_clk), .rst_n(rst_n), .clk_main_loop(cml), .enable(enable),
      .PS2C(ps2c), .PS2D(ps2d), .reading(reading), .data(data), .done(done), .err(err)
   );
   always begin
      #5;
      if (clk_en) qzt_clk = ~qzt_clk;
   end
   always #100 cml = ~cml;
   // data/err settle on the edge that ends the done cycle, so compare one cycle later
   always @(negedge qzt_clk) begin
      if (reading) saw_reading = 1'b1;
      if (chk_pend) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done data=%h", data);
         end else begin
            exp_v = sb_q.pop_front();
            n_checks += 2;
            if (data !== exp_v[10:0]) begin
               n_fail++;
               $display("FAIL sb_data got=%h exp=%h", data, exp_v[10:0]);
            end
            if (err !== exp_v[11]) begin
               n_fail++;
               $display("FAIL sb_err got=%b exp=%b", err, exp_v[11]);
            end
         end
      end
      chk_pend = done;
      if (done) done_cnt++;
   end
   task automatic send(input logic [10:0] bits, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         d_drv = bits[10-i];
         #HALF c_drv = 1'b0;
         #HALF c_drv = 1'b1;
         if (reading) rd_hi++;
      end
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      enable = 1'b1;
      repeat (5) @(negedge qzt_clk);
      n_checks += 4;
      if (reading !== 1'b0) begin n_fail++; $display("FAIL rst_reading got=%b exp=0", reading); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
      if (data !== 11'h000) begin n_fail++; $display("FAIL rst_data got=%h exp=000", data); end
      rst_n = 1'b1;
      #1000;
   endtask
   task automatic test_valid;
      d0 = done_cnt;
      rd_hi = 0;
      sb_q.push_back({1'b0, 11'h17F});
      send(11'h17F, 0, 10);
      #2000;
      n_checks += 3;
      if (rd_hi != 10) begin n_fail++; $display("FAIL valid_reading got=%0d exp=10", rd_hi); end
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL valid_done got=%0d exp=1", done_cnt - d0); end
      if (data[9:2] !== 8'h5F) begin n_fail++; $display("FAIL valid_byte got=%h exp=5f", data[9:2]); end
   endtask
   task automatic test_parity_err;
      d0 = done_cnt;
      sb_q.push_back({1'b1, 11'h17D});
      send(11'h17D, 0, 10);
      #2000;
      n_checks++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL parity_done got=%0d exp=1", done_cnt - d0); end
   endtask
   task automatic test_stop_err;
      sb_q.push_back({1'b1, 11'h17E});
      send(11'h17E, 0, 10);
      #2000;
      n_checks++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL stop_err got=%b exp=1", err); end
      sb_q.push_back({1'b0, 11'h17F});
      send(11'h17F, 0, 10);
      #2000;
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL stop_recover_err got=%b exp=0", err); end
   endtask
   task automatic test_timeout;
      d0 = done_cnt;
      send(11'h17F, 0, 4);
      #15000;
      n_checks++;
      if (reading !== 1'b1) begin n_fail++; $display("FAIL timeout_early got=%b exp=1", reading); end
      for (int k = 0; k < 4000 && reading; k++) @(negedge qzt_clk);
      n_checks += 4;
      if (reading !== 1'b0) begin n_fail++; $display("FAIL timeout_reading got=%b exp=0", reading); end
      if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got=%b exp=1", err); end
      if (data !== 11'h17F) begin n_fail++; $display("FAIL timeout_data got=%h exp=17f", data); end
      if (done_cnt != d0) begin n_fail++; $display("FAIL timeout_done got=%0d exp=0", done_cnt - d0); end
      #2000;
   endtask
   task automatic test_enable;
      d0 = done_cnt;
      enable = 1'b0;
      saw_reading = 1'b0;
      send(11'h17F, 0, 10);
      #2000;
      n_checks += 2;
      if (saw_reading !== 1'b0) begin n_fail++; $display("FAIL dis_reading got=%b exp=0", saw_reading); end
      if (done_cnt != d0) begin n_fail++; $display("FAIL dis_done got=%0d exp=0", done_cnt - d0); end
      enable = 1'b1;
      #1000;
      send(11'h17F, 0, 3);
      n_checks++;
      if (reading !== 1'b1) begin n_fail++; $display("FAIL en_mid_reading got=%b exp=1", reading); end
      @(negedge qzt_clk);
      enable = 1'b0;
      repeat (3) @(posedge qzt_clk);
      @(negedge qzt_clk);
      n_checks++;
      if (reading !== 1'b0) begin n_fail++; $display("FAIL en_drop_reading got=%b exp=0", reading); end
      send(11'h17F, 4, 10);
      #2000;
      n_checks += 3;
      if (done_cnt != d0) begin n_fail++; $display("FAIL en_drop_done got=%0d exp=0", done_cnt - d0); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL en_drop_err got=%b exp=0", err); end
      if (data !== 11'h17F) begin n_fail++; $display("FAIL en_drop_data got=%h exp=17f", data); end
      enable = 1'b1;
      #1000;
   endtask
   task automatic test_ignore_idle_edge;
      d0 = done_cnt;
      d_drv = 1'b1;
      #HALF c_drv = 1'b0;
      #HALF c_drv = 1'b1;
      #HALF;
      sb_q.push_back({1'b0, 11'h003});
      send(11'h003, 0, 10);
      #2000;
      n_checks++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL idle_edge_done got=%0d exp=1", done_cnt - d0); end
   endtask
   task automatic test_async_reset;
      send(11'h17F, 0, 3);
      n_checks++;
      if (reading !== 1'b1) begin n_fail++; $display("FAIL prerst_reading got=%b exp=1", reading); end
      @(negedge qzt_clk);
      clk_en = 1'b0;
      #20 rst_n = 1'b0;
      #1;
      n_checks += 4;
      if (reading !== 1'b0) begin n_fail++; $display("FAIL arst_reading got=%b exp=0", reading); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done got=%b exp=0", done); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL arst_err got=%b exp=0", err); end
      if (data !== 11'h000) begin n_fail++; $display("FAIL arst_data got=%h exp=000", data); end
      c_drv = 1'b1;
      d_drv = 1'b1;
      #50 rst_n = 1'b1;
      clk_en = 1'b1;
      #2000;
      n_checks++;
      if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_left got=%0d exp=0", sb_q.size()); end
   endtask
   initial begin
      test_reset;
      test_valid;
      test_parity_err;
      test_stop_err;
      test_timeout;
      test_enable;
      test_ignore_idle_edge;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
